// File: rtl/packet_filter_if.sv
// Avalon-ST streaming interface carrying packet framing (sop/eop/empty) and channel.
// Used on both sides of packet_filter.
interface avalon_st_if #(
   parameter int DWIDTH        = 64,
   parameter int EMPTY_WIDTH   = 3,
   parameter int CHANNEL_WIDTH = 1
);
   logic [DWIDTH-1:0]        data;
   logic [EMPTY_WIDTH-1:0]   empty;
   logic [CHANNEL_WIDTH-1:0] channel;
   logic                     valid;
   logic                     ready;
   logic                     sop;
   logic                     eop;

   modport sink (input data, empty, channel, valid, sop, eop, output ready);
   modport src  (output data, empty, channel, valid, sop, eop, input ready);
endinterface

// File: rtl/packet_filter.sv
// packet_filter: store-and-forward drop stage.
// Whole packets are buffered. A packet is released only if at least one of its
// beats carried a nonzero channel; otherwise it is rewound away.
// Optional macro PACKET_FILTER_STATS_EN enables the saturating pass/drop counters;
// without it both counter ports are tied to zero.
module packet_filter #(
   parameter int AST_DWIDTH    = 64,
   parameter int CHANNEL_WIDTH = 1,
   parameter int DEPTH         = 256
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   avalon_st_if.sink   ast_sink_if,
   avalon_st_if.src    ast_src_if,
   output logic [31:0] pass_cnt_o,
   output logic [31:0] drop_cnt_o
);
   localparam int EMPTY_WIDTH = $clog2(AST_DWIDTH/8);
   localparam int AW          = $clog2(DEPTH);
   localparam int PW          = AW + 1;                 // extra bit separates full from empty
   localparam int WW          = AST_DWIDTH + 2 + EMPTY_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_STORE, S_DROP} state_t;

   state_t                   state_q, state_d;
   logic [PW-1:0]            wr_spec_q, wr_spec_d;
   logic [PW-1:0]            commit_q, commit_d;
   logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
   logic                     keep_q, keep_d;
   logic                     pf_vld_q, pf_vld_d;
   logic                     out_vld_q, out_vld_d;
   logic [WW-1:0]            out_word_q, out_word_d;
   logic [WW-1:0]            mem [DEPTH];
   logic [WW-1:0]            mem_rdata_q;

   logic [CHANNEL_WIDTH-1:0] sink_channel;
   logic                     full, overflow, in_pkt, ready_c, accept;
   logic                     abandon, mem_we, keep_n, fin_keep, fin_drop;
   logic [PW-1:0]            wptr, wptr_end;
   logic [WW-1:0]            wdata;
   logic                     rd_en, pf_move, out_pop;

   assign sink_channel = ast_sink_if.channel;
   // Ready is forced low while reset is asserted, independent of the clock.
   assign ast_sink_if.ready = ready_c & rst_n_i;

   // Write side: speculative packet store, keep tracking, commit or rewind.
   always_comb begin
      full     = (wr_spec_q - rd_ptr_q) == PW'(DEPTH);
      // Only an oversized packet can fill the buffer while nothing committed is pending.
      overflow = (state_q == S_STORE) && full && (commit_q == rd_ptr_q);
      in_pkt   = (state_q == S_STORE) && !overflow;
      // Outside STORE, wr_spec equals commit, so full here means committed data owns
      // every word; hold off rather than overwrite it.
      ready_c  = !full || overflow;
      accept   = ast_sink_if.valid && ready_c && rst_n_i;
      abandon  = overflow || (in_pkt && accept && ast_sink_if.sop);
      mem_we   = accept && (ast_sink_if.sop || in_pkt);
      keep_n   = (ast_sink_if.sop ? 1'b0 : keep_q) | (|sink_channel);
      fin_keep = mem_we && ast_sink_if.eop && keep_n;
      fin_drop = mem_we && ast_sink_if.eop && !keep_n;
      // A fresh sop always lands at the commit point.
      wptr     = (in_pkt && !abandon) ? wr_spec_q : commit_q;
      wptr_end = wptr + PW'(1);
      wdata    = {ast_sink_if.data, ast_sink_if.sop, ast_sink_if.eop, ast_sink_if.empty};

      wr_spec_d = wr_spec_q;
      commit_d  = commit_q;
      if (abandon)  wr_spec_d = commit_q;
      if (mem_we)   wr_spec_d = wptr_end;
      if (fin_drop) wr_spec_d = commit_q;
      if (fin_keep) commit_d  = wptr_end;

      state_d = state_q;
      keep_d  = keep_q;
      if (mem_we) begin
         keep_d  = keep_n;
         state_d = ast_sink_if.eop ? S_IDLE : S_STORE;
      end else if (accept && ast_sink_if.eop && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else if (overflow) begin
         state_d = S_DROP;
      end
   end

   // Read side: memory output register acts as prefetch stage ahead of the output register.
   always_comb begin
      out_pop    = out_vld_q && ast_src_if.ready;
      pf_move    = pf_vld_q && (!out_vld_q || ast_src_if.ready);
      rd_en      = (rd_ptr_q != commit_q) && (!pf_vld_q || pf_move);
      rd_ptr_d   = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
      pf_vld_d   = rd_en || (pf_vld_q && !pf_move);
      out_vld_d  = pf_move || (out_vld_q && !out_pop);
      out_word_d = pf_move ? mem_rdata_q : out_word_q;
   end

   // Buffer memory with registered read; contents need no reset.
   always_ff @(posedge clk_i) begin
      if (mem_we) mem[wptr[AW-1:0]] <= wdata;
      if (rd_en)  mem_rdata_q <= mem[rd_ptr_q[AW-1:0]];
   end

   // State, pointer and output registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         wr_spec_q  <= '0;
         commit_q   <= '0;
         rd_ptr_q   <= '0;
         keep_q     <= 1'b0;
         pf_vld_q   <= 1'b0;
         out_vld_q  <= 1'b0;
         out_word_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_spec_q  <= wr_spec_d;
         commit_q   <= commit_d;
         rd_ptr_q   <= rd_ptr_d;
         keep_q     <= keep_d;
         pf_vld_q   <= pf_vld_d;
         out_vld_q  <= out_vld_d;
         out_word_q <= out_word_d;
      end
   end

   assign ast_src_if.valid   = out_vld_q;
   assign ast_src_if.data    = out_word_q[WW-1 -: AST_DWIDTH];
   assign ast_src_if.sop     = out_word_q[EMPTY_WIDTH+1];
   assign ast_src_if.eop     = out_word_q[EMPTY_WIDTH];
   assign ast_src_if.empty   = out_word_q[EMPTY_WIDTH-1:0];
   assign ast_src_if.channel = '0;

`ifdef PACKET_FILTER_STATS_EN
   logic [31:0] pass_cnt_q, pass_cnt_d;
   logic [31:0] drop_cnt_q, drop_cnt_d;
   logic [1:0]  drop_inc;

   // Saturating counters; a restart that also drops a one-word packet counts two drops.
   always_comb begin
      drop_inc   = {1'b0, abandon} + {1'b0, fin_drop};
      pass_cnt_d = pass_cnt_q;
      if (fin_keep && (pass_cnt_q != 32'hFFFF_FFFF)) pass_cnt_d = pass_cnt_q + 32'd1;
      if (drop_cnt_q > (32'hFFFF_FFFF - 32'(drop_inc))) drop_cnt_d = 32'hFFFF_FFFF;
      else                                              drop_cnt_d = drop_cnt_q + 32'(drop_inc);
   end

   // Counter registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pass_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         pass_cnt_q <= pass_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign pass_cnt_o = pass_cnt_q;
   assign drop_cnt_o = drop_cnt_q;
`else
   assign pass_cnt_o = 32'h0;
   assign drop_cnt_o = 32'h0;
`endif
endmodule

// File: doc/packet_filter.md
Name: packet_filter

Overview:
Store-and-forward drop stage placed directly downstream of the packet classifier on the 64-bit Avalon-ST path. Each incoming packet is buffered in an internal memory. The packet is forwarded on the source port only if its channel was nonzero on at least one accepted beat; otherwise it is discarded without being emitted. Output packets are contiguous: src.valid never drops mid-packet.

Parameters:
AST_DWIDTH, 64, data width in bits (multiple of 8)
CHANNEL_WIDTH, 1, width of channel
DEPTH, 256, buffer depth in words (power of 2, >= 4); longest packet that can be passed is DEPTH words
EMPTY_WIDTH, $clog2(AST_DWIDTH/8), local, width of empty

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
ast_sink_if  avalon_st_if.sink  data AST_DWIDTH, empty EMPTY_WIDTH, channel CHANNEL_WIDTH, valid/ready/sop/eop 1  input from classifier
ast_src_if  avalon_st_if.src  same widths  filtered output; src.channel always driven '0
pass_cnt_o  out  32  packets forwarded (see Optional Feature)
drop_cnt_o  out  32  packets discarded (see Optional Feature)

Behaviour:
- One clock. Reset is asynchronous and active-low. Reset clears all pointers, state, output register and counters.
- Reset values: src.valid=0, src.sop=0, src.eop=0, src.data='0, src.empty='0, src.channel='0, sink.ready=0 while rst_n_i=0, counters=0.
- Sink beat accepted when sink.valid && sink.ready. Words are stored as {data, sop, eop, empty} at the speculative write pointer wr_spec.
- Pointers:
  - commit_ptr: end of the last accepted packet.
  - rd_ptr: read position. All pointers carry one extra bit so full and empty can be told apart.
  - Wrap at DEPTH.
- Write FSM:
  - IDLE: ready=1. Non-sop beats are discarded. A sop beat is written, wr_spec is incremented, keep=|channel, and the FSM goes to STORE. A sop+eop beat (single-word packet) is resolved immediately, as in STORE-on-eop.
  - STORE: ready = !(wr_spec - rd_ptr == DEPTH). Each beat is written and keep |= |channel.
    - On eop: if keep, then commit_ptr <= wr_spec+1 and pass_cnt increments. Else wr_spec <= commit_ptr (rewind) and drop_cnt increments. The FSM returns to IDLE.
    - On sop without a preceding eop: rewind to commit_ptr, drop_cnt increments, the new beat is written as a fresh sop, and the FSM stays in STORE.
    - Buffer full with commit_ptr == rd_ptr (the packet alone exceeds DEPTH): rewind, drop_cnt increments, and the FSM goes to DROP.
    - Buffer full with committed data pending: ready=0 until the reader frees space.
  - DROP: ready=1. Beats are discarded until an eop beat, then the FSM goes to IDLE. A sop beat in DROP is treated as in IDLE.
- Read side:
  - Synchronous-read memory feeding a single output register with prefetch.
  - src.valid=1 whenever the output register holds a word.
  - Output fields stay stable while src.valid && !src.ready.
  - The output register is reloaded when it is empty or is being consumed, provided rd_ptr != commit_ptr.
  - Latency: eop accepted at edge N, so the packet's first word has src.valid=1 at edge N+2 at the earliest. Throughput after that is 1 word/cycle while src.ready=1.
- Commit and read in the same cycle are legal. A rewind never moves below commit_ptr, so committed data is never corrupted.
- Counters are 32-bit and saturate at 0xFFFF_FFFF.

Optional Feature:
PACKET_FILTER_STATS_EN.
- Defined: pass_cnt_o and drop_cnt_o count as described above.
- Undefined: the counters are not implemented and both ports are tied to 32'h0. Filtering behaviour is identical either way.

Test Plan:
- 3-word packet, channel=1 on eop beat only → identical 3 words on src (sop on word 0, eop and empty copied on word 2), src.valid first high 2 cycles after eop; pass_cnt_o=1.
- 4-word packet, channel=0 on all beats, followed by a 2-word packet with channel=1 → only the 2-word packet appears on src; drop_cnt_o=1, pass_cnt_o=1.
- DEPTH=16, 20-word packet with channel=1 → nothing emitted, ready stays 1 through eop, drop_cnt_o=1; a following 5-word packet with channel=1 passes intact.
- sop, 2 beats, then a new sop without eop, 3 beats ending in eop with channel=1 → only the 3-word packet is emitted; drop_cnt_o=1.
- Random src.ready (50%) over 100 random packets, 1–12 words, random channel → the output stream equals the input filtered by keep, in order, with no gaps inside a packet and data held stable while ready=0.
- Assert rst_n_i=0 mid-packet, asynchronously between edges → src.valid=0 immediately, counters 0; after release, a new 1-word packet (sop+eop, channel=1, empty=3) is emitted with empty=3.
